// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Receive side of the pc_one SoC UART. Oversamples an asynchronous 8N1 line in
// the core clock domain, assembles bytes LSB-first and hands them to the core
// through a valid/ready receive buffer. Framing errors and overruns are
// reported as single-cycle pulses.
//
// Optional feature macro: UART_RX_FIFO_EN
//   defined     : receive buffer is a FIFO_DEPTH-entry circular FIFO
//   not defined : receive buffer is a single holding register
//
// Parameters
//   CLKS_PER_BIT : core clocks per bit period (8..65535)
//   FIFO_DEPTH   : FIFO entries when UART_RX_FIFO_EN is defined (power of 2, >=2)
//
// Ports
//   clk_from_FPGA         in   core clock
//   rst_from_FPGA         in   asynchronous active-high reset
//   uart_rx_pin_from_FPGA in   serial line, idle high, asynchronous
//   rx_data               out  byte at head of the buffer (valid with rx_valid)
//   rx_valid              out  buffer non-empty
//   rx_ready              in   consumer pop, taken when rx_valid && rx_ready
//   frame_err             out  one-cycle pulse: stop bit sampled low
//   overrun               out  one-cycle pulse: completed byte dropped (full)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_from_FPGA,
  input  logic       rst_from_FPGA,
  input  logic       uart_rx_pin_from_FPGA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Elaboration-time guards on the parameter contract.
  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_rx: CLKS_PER_BIT out of range 8..65535");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer plus edge register. All three flops reset high so the
  // line looks idle coming out of reset.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_rx_s;

  always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
    if (rst_from_FPGA) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_pin_from_FPGA;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rx_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Frame FSM. Results of the stop-bit sample are registered into one-cycle
  // request flags that the buffer consumes on the following edge.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_push_req;
  logic             r_ferr_req;

  always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
    if (rst_from_FPGA) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_push_req <= 1'b0;
      r_ferr_req <= 1'b0;
    end else begin
      r_push_req <= 1'b0;
      r_ferr_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Only a genuine 1->0 transition starts a frame, so a line held low
          // after a break or framing error is ignored until it recovers.
          if (r_prev && !w_rx_s) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            // Line back high at mid start bit: treat as a glitch.
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            // Back to IDLE on the sample edge so a back-to-back start bit is
            // never missed.
            r_state   <= S_IDLE;
            if (w_rx_s) begin
              r_push_req <= 1'b1;
            end else begin
              r_ferr_req <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive buffer. r_shift stays stable for at least half a bit after the
  // stop sample, so it is still the completed byte when r_push_req is seen.
  // ---------------------------------------------------------------------------
  logic w_pop;
  logic w_push;

  assign w_pop = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_rd_next;
  logic             w_full;

  assign rx_valid  = (r_count != '0);
  assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  // A simultaneous pop frees a slot, so a full buffer still accepts the push.
  assign w_push    = r_push_req && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;

  always_ff @(posedge clk_from_FPGA) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
    if (rst_from_FPGA) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      rx_data   <= 8'h00;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= r_ferr_req;
      overrun   <= r_push_req && w_full && !w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // rx_data is a registered copy of the head entry. On a pop the new head
      // is either the next stored entry or, if the buffer held only one byte,
      // the byte being pushed this cycle.
      if (w_pop) begin
        if (r_count > (PTR_W + 1)'(1)) begin
          rx_data <= r_mem[w_rd_next];
        end else if (w_push) begin
          rx_data <= r_shift;
        end
      end else if (w_push && (r_count == '0)) begin
        rx_data <= r_shift;
      end
    end
  end
`else
  logic r_hold_valid;

  assign rx_valid = r_hold_valid;
  assign w_push   = r_push_req && (!r_hold_valid || w_pop);

  always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
    if (rst_from_FPGA) begin
      r_hold_valid <= 1'b0;
      rx_data      <= 8'h00;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= r_ferr_req;
      overrun   <= r_push_req && r_hold_valid && !w_pop;
      if (w_push) begin
        r_hold_valid <= 1'b1;
        rx_data      <= r_shift;
      end else if (w_pop) begin
        r_hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx at CLKS_PER_BIT = 104. Works for
// both buffer builds (UART_RX_FIFO_EN defined or not).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int C = 104;
`ifdef UART_RX_FIFO_EN
  localparam int BUF_N = 4;
`else
  localparam int BUF_N = 1;
`endif

  logic       clk;
  logic       rst;
  logic       pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitors: rising edges and total high cycles.
  int ferr_pulses = 0;
  int ferr_cycles = 0;
  int ovr_pulses  = 0;
  int ovr_cycles  = 0;
  logic ferr_d = 1'b0;
  logic ovr_d  = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_from_FPGA        (clk),
    .rst_from_FPGA        (rst),
    .uart_rx_pin_from_FPGA(pin),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .frame_err            (frame_err),
    .overrun              (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cycles++;
      if (overrun) ovr_cycles++;
      if (frame_err && !ferr_d) ferr_pulses++;
      if (overrun && !ovr_d) ovr_pulses++;
    end
    ferr_d = frame_err;
    ovr_d  = overrun;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame. The first posedge waited on is P0; the line falls
  // just after P0 and every later bit changes just after P0 + k*C.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1 pin = bits[k];
      repeat (C) @(posedge clk);
    end
    #1 pin = 1'b1;
    $display("sent 0x%02h stop=%0d", b, stop_bit);
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    @(negedge clk);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, exp);
    $display("pop 0x%02h", rx_data);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  initial begin
    int f0;
    int fc0;
    int o0;
    int oc0;
    logic [7:0] pb;

    rst      = 1'b1;
    pin      = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 0x55 with exact valid timing: sample 9 at P0+991, valid after P0+992.
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (991) @(posedge clk);
        @(negedge clk);
        check("t55_valid_early", rx_valid, 0);
        @(negedge clk);
        check("t55_valid", rx_valid, 1);
        check("t55_data", rx_data, 8'h55);
      end
    join
    pop_expect(8'h55, "t55_pop");
    @(negedge clk);
    check("t55_empty", rx_valid, 0);

    // Start-bit glitch: 20 low cycles is rejected at the mid-start sample.
    f0 = ferr_pulses;
    @(posedge clk);
    #1 pin = 1'b0;
    repeat (20) @(posedge clk);
    #1 pin = 1'b1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", ferr_pulses - f0, 0);
    $display("glitch done");

    // Framing error then a clean frame.
    f0  = ferr_pulses;
    fc0 = ferr_cycles;
    send_frame(8'hA3, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ferr_pulses", ferr_pulses - f0, 1);
    check("ferr_width", ferr_cycles - fc0, 1);
    check("ferr_valid", rx_valid, 0);
    send_frame(8'h3C, 1'b1);
    pop_expect(8'h3C, "t3c");

    // Overrun: BUF_N bytes fit, the next one is dropped.
    o0  = ovr_pulses;
    oc0 = ovr_cycles;
    for (int i = 1; i <= BUF_N; i++) begin
      send_frame(8'(i), 1'b1);
    end
    @(negedge clk);
    check("ovr_none_yet", ovr_pulses - o0, 0);
    send_frame(8'(BUF_N + 1), 1'b1);
    @(negedge clk);
    check("ovr_pulse", ovr_pulses - o0, 1);
    check("ovr_width", ovr_cycles - oc0, 1);
    for (int i = 1; i <= BUF_N; i++) begin
      pop_expect(8'(i), "ovr_pop");
    end
    @(negedge clk);
    check("ovr_empty", rx_valid, 0);

    // Full buffer, pop on the same edge the new byte lands: no overrun.
    o0 = ovr_pulses;
    for (int i = 0; i < BUF_N; i++) begin
      send_frame(8'(8'h10 + i), 1'b1);
    end
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (991) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("pp_head", rx_data, (BUF_N > 1) ? 8'h11 : 8'h77);
      end
    join
    check("pp_no_ovr", ovr_pulses - o0, 0);
    for (int i = 1; i < BUF_N; i++) begin
      pop_expect(8'(8'h10 + i), "pp_pop");
    end
    pop_expect(8'h77, "pp_tail");
    @(negedge clk);
    check("pp_empty", rx_valid, 0);

    // Reset during DATA bit 4, with a byte already buffered.
    send_frame(8'h99, 1'b1);
    @(negedge clk);
    check("rr_pre_valid", rx_valid, 1);
    pb = 8'h5A;
    @(posedge clk);
    #1 pin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (C) @(posedge clk);
      #1 pin = pb[k];
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pin = 1'b1;
    @(negedge clk);
    check("rr_data", rx_data, 8'h00);
    check("rr_valid", rx_valid, 0);
    check("rr_ferr", frame_err, 0);
    check("rr_ovr", overrun, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rr_idle_valid", rx_valid, 0);
    send_frame(8'hC7, 1'b1);
    pop_expect(8'hC7, "rr_c7");
    @(negedge clk);
    check("rr_empty", rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
